// File: rtl/vecmat_dot_pipe.sv
// vecmat_dot_pipe: streaming fixed-point vector dot product.
// Each accepted beat is multiplied lane by lane, the products are summed and
// the sum is folded into a wide accumulator. The result is presented once the
// final beat has drained through the three-stage pipeline.
// Optional build macro VECMAT_SAT_EN: saturate data_out instead of wrapping.
module vecmat_dot_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 12,
   parameter int LANES      = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        in_last,
   input  logic [LANES*DATA_WIDTH-1:0] data_in,
   input  logic [LANES*DATA_WIDTH-1:0] w_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH-1:0]       data_out,
   output logic [15:0]                 beat_count
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int AW = PW + $clog2(LANES);
   localparam int VW = LANES * DATA_WIDTH;

   typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

   state_t                 state, state_nxt;
   logic [1:0]             drain_cnt;
   logic                   accept, handshake;

   logic                   s1_valid;
   logic [VW-1:0]          s1_data, s1_w;
   logic                   s2_valid;
   logic signed [PW-1:0]   prod_c [LANES];
   logic signed [PW-1:0]   s2_prod [LANES];
   logic signed [AW-1:0]   lane_sum;
   logic signed [AW-1:0]   acc;

   assign accept    = in_valid & in_ready;
   assign handshake = out_valid & out_ready;

   // Next-state and handshake outputs; in_ready is forced low during reset.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = ~reset;
            if (in_valid && in_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt == 2'd2) state_nxt = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
   end

   // State register and drain counter (acceptance edge plus two more edges).
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ACCUM;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : '0;
      end
   end

   // Stage 1: capture operands of an accepted beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_w     <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_data <= data_in;
            s1_w    <= w_in;
         end
      end
   end

   // Full-width signed lane products, floor-shifted back to the element scale.
   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         prod_c[i] = (PW'($signed(s1_data[i*DATA_WIDTH +: DATA_WIDTH])) *
                      PW'($signed(s1_w[i*DATA_WIDTH +: DATA_WIDTH]))) >>> FRAC_BITS;
      end
   end

   // Stage 2: register the shifted products.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) s2_prod[i] <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            for (int unsigned i = 0; i < LANES; i++) s2_prod[i] <= prod_c[i];
         end
      end
   end

   // Sum of all lane products, sign-extended to accumulator width.
   always_comb begin
      lane_sum = '0;
      for (int unsigned i = 0; i < LANES; i++) lane_sum += AW'(s2_prod[i]);
   end

   // Stage 3: wrap-around accumulation; cleared when the result is taken.
   always_ff @(posedge clk) begin
      if (reset || handshake) acc <= '0;
      else if (s2_valid)      acc <= acc + lane_sum;
   end

   // Saturating count of beats accepted into the current vector.
   always_ff @(posedge clk) begin
      if (reset || handshake)                  beat_count <= '0;
      else if (accept && beat_count != 16'hFFFF) beat_count <= beat_count + 16'd1;
   end

`ifdef VECMAT_SAT_EN
   // Clamp when the bits above the sign position disagree with the sign.
   always_comb begin
      data_out = acc[DATA_WIDTH-1:0];
      if (acc[AW-1] && !(&acc[AW-1:DATA_WIDTH-1]))
         data_out = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else if (!acc[AW-1] && (|acc[AW-1:DATA_WIDTH-1]))
         data_out = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   end
`else
   logic acc_unused;
   // Wrap: only the low element-width bits of the accumulator reach the output.
   always_comb begin
      data_out   = acc[DATA_WIDTH-1:0];
      acc_unused = ^acc[AW-1:DATA_WIDTH];
   end
`endif

endmodule

// File: doc/vecmat_dot_pipe.md
VECMAT_DOT_PIPE -- requirements
Module: vecmat_dot_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of each signed fixed-point element.
REQ-002 SHALL have parameter FRAC_BITS, default 12: number of fraction bits in every element.
REQ-003 SHALL have parameter LANES, default 16: number of elements per input beat, a power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the current beat is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-008 SHALL have port in_last, input, 1 bit: the beat is the final beat of the vector.
REQ-009 SHALL have port data_in, input, LANES*DATA_WIDTH bits: vector elements, lane i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port w_in, input, LANES*DATA_WIDTH bits: weight elements, packed the same way as data_in.
REQ-011 SHALL have port out_valid, output, 1 bit: the dot-product result is available.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port data_out, output, DATA_WIDTH bits: the signed fixed-point dot product.
REQ-014 SHALL have port beat_count, output, 16 bits: number of beats accepted into the current vector.

Function
REQ-015 SHALL accept a beat only on a cycle where in_valid and in_ready are both 1.
REQ-016 SHALL form each lane product as the full two's-complement product of width 2*DATA_WIDTH, then arithmetic-shift it right by FRAC_BITS (floor rounding).
REQ-017 SHALL sum all LANES shifted products of a beat in an adder tree, and add the sum into an accumulator of width 2*DATA_WIDTH+log2(LANES) using wrap arithmetic.
REQ-018 SHALL use a fixed pipeline: edge 1 registers the operands, edge 2 registers the products, edge 3 updates the accumulator.
REQ-019 SHALL run the state machine ACCUM -> DRAIN -> HOLD -> ACCUM.
REQ-020 In ACCUM, SHALL hold in_ready=1; acceptance of an in_last beat SHALL move the state to DRAIN.
REQ-021 In DRAIN, SHALL hold in_ready=0 and SHALL count 3 edges, including the acceptance edge, then move to HOLD.
REQ-022 SHALL assert out_valid for the first time exactly 3 edges after the edge that accepts the in_last beat.
REQ-023 In HOLD, SHALL hold in_ready=0 and out_valid=1, and SHALL keep data_out stable until out_ready=1.
REQ-024 On the edge where out_valid=1 and out_ready=1, SHALL clear the accumulator and beat_count, deassert out_valid, and return to ACCUM.
REQ-025 SHALL NOT let a new beat be accepted on the handshake cycle itself, because in_ready=0 in HOLD.
REQ-026 SHALL form data_out from the accumulator bits [DATA_WIDTH-1:0] (wrap) when VECMAT_SAT_EN is undefined.
REQ-027 SHALL increment beat_count on each accepted beat, and SHALL saturate it at 0xFFFF.
REQ-028 When in_valid=0 in ACCUM, SHALL leave the pipeline and accumulator unchanged.
REQ-029 SHALL treat a single-beat vector (in_last on the first beat) as valid, with the same latency as a multi-beat vector.

Reset
REQ-030 While reset=1 at a clock edge, SHALL clear all pipeline registers and the accumulator, set the state to ACCUM, and drive out_valid=0, data_out=0 and beat_count=0.
REQ-031 During reset, in_ready SHALL read 0; it SHALL be 1 on the first cycle after reset deasserts.
REQ-032 A reset asserted in DRAIN or HOLD SHALL discard the in-flight vector, and no out_valid SHALL follow it.

Configuration
REQ-033 When VECMAT_SAT_EN is defined, SHALL clamp data_out to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] when the accumulator exceeds that range.
REQ-034 When VECMAT_SAT_EN is undefined, SHALL apply wrap truncation only, with no added logic.

Verification (LANES=4, DATA_WIDTH=16, FRAC_BITS=12)
REQ-035 SHALL cover: one beat, all lanes 0x1000 x 0x1000, in_last=1 -> out_valid 3 edges later, data_out=0x4000, beat_count=1.
REQ-036 SHALL cover: two beats of all-0x1000 operands -> data_out=0x8000 without VECMAT_SAT_EN, and 0x7FFF with it.
REQ-037 SHALL cover: lane0 0xF000 x 0x1000, other lanes 0 -> data_out=0xF000, a negative result.
REQ-038 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> out_valid=1, data_out stable, in_ready=0 throughout; handshake -> in_ready=1 next cycle and beat_count=0.
REQ-039 SHALL cover: reset pulsed 1 edge after in_last is accepted -> out_valid never asserts; a following 1-beat vector gives the correct result, uncontaminated by the discarded vector.
REQ-040 SHALL cover: in_valid gaps of 2 cycles between 3 beats -> result identical to the gap-free case; beat_count=3.
